stream_demux: RTL and testbench
===============================

# stream_demux

Packet-aware 1-to-N stream router: the transmit-side counterpart of the stream arbiter. It accepts one merged stream carrying data, QoS, stream ID and last, and delivers each packet intact to the output stream selected by the ID on the packet's first beat. Each output has one registered stage. The block sits where a merged, ID-tagged stream fans back out to per-stream consumers.

## Interface
- T_DATA_WIDTH, 8, data width
- T_QOS__WIDTH, 4, QoS width, carried through unchanged
- STREAM_COUNT, 2, number of output streams (≥2)
- T_ID___WIDTH, $clog2(STREAM_COUNT), localparam, ID width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_data_i  in  T_DATA_WIDTH  input data
- s_qos_i  in  T_QOS__WIDTH  input QoS
- s_id_i  in  T_ID___WIDTH  destination stream, sampled on first beat only
- s_last_i  in  1  last beat of packet
- s_valid_i  in  1  input valid
- s_ready_o  out  1  input ready
- m_data_o  out  T_DATA_WIDTH×[STREAM_COUNT]  per-output data (unpacked array)
- m_qos_o  out  T_QOS__WIDTH×[STREAM_COUNT]  per-output QoS
- m_last_o  out  [STREAM_COUNT]  per-output last
- m_valid_o  out  [STREAM_COUNT]  per-output valid
- m_ready_i  in  [STREAM_COUNT]  per-output ready
- drop_cnt_o  out  16  count of dropped packets, saturating

## Operation
- States: IDLE (next accepted beat is a packet head), PKT (locked to sel), DROP (discarding the current packet).
- IDLE: on an accepted beat (s_valid_i & s_ready_o), latch sel = s_id_i.
  - If s_last_i=1, stay IDLE (single-beat packet).
  - Otherwise go to PKT.
  - Out-of-range ID handling: see Configuration.
- PKT: every accepted beat goes to output sel, regardless of s_id_i. An accepted beat with s_last_i=1 returns to IDLE.
- DROP: s_ready_o=1. Beats are consumed and discarded. An accepted beat with s_last_i=1 returns to IDLE.
- Output stage k is one register holding data, qos and last, plus valid[k].
  - Load when a beat routed to k is accepted.
  - Clear valid[k] on m_valid_o[k] & m_ready_i[k] if no new load occurs in the same cycle.
  - Load and drain in the same cycle: the stage holds the new beat and valid stays 1.
- s_ready_o (combinational):
  - In PKT: !valid[sel] | m_ready_i[sel].
  - In IDLE: the same expression, using the current s_id_i in place of sel.
- Only one output's stage can change per cycle from the input side. Other outputs drain independently.
- m_valid_o never depends combinationally on m_ready_i. Stable data is held while valid & !ready.
- Reset mid-packet: everything returns to reset values. The remainder of an interrupted packet is treated as a new packet head.

## Timing
- Reset values:
  - m_valid_o=0, m_data_o=0, m_qos_o=0, m_last_o=0.
  - s_ready_o evaluates to 1 (all stages empty, state IDLE).
  - drop_cnt_o=0.
- Latency: one cycle from input acceptance to m_valid_o.
- Throughput: one beat per cycle when the destination holds m_ready_i=1.
- Back-to-back packets to different outputs: no bubble. The head beat of packet B is accepted in the cycle after the last beat of packet A.
- Head-of-line blocking: a stalled destination blocks the input. There is no bypass to other outputs.
- drop_cnt_o increments on the accepted head beat of a dropped packet. It saturates at 16'hFFFF.

## Configuration
- STREAM_DEMUX_DROP_EN defined:
  - A head beat with s_id_i ≥ STREAM_COUNT enters DROP, or stays in IDLE if s_last_i=1.
  - The packet is discarded and drop_cnt_o counts it.
  - s_ready_o is 1 for every beat of a dropped packet.
- Not defined:
  - Out-of-range IDs are routed to output STREAM_COUNT-1 and the DROP state is not built.
  - drop_cnt_o is tied to 0.
  - Only reachable when STREAM_COUNT is not a power of two.

## Test plan
- Reset with s_valid_i=1 → all m_valid_o=0 and drop_cnt_o=0. The first beat is accepted one cycle after rst_n rises, and m_valid_o[id] rises one cycle later.
- 3-beat packet id=1, data 0xA1/A2/A3, last on the 3rd beat, all ready=1 → m_valid_o[1] high for 3 consecutive cycles with the same data and last. m_valid_o[0] stays 0 throughout.
- Mid-packet s_id_i changes 1→0 while in PKT → every beat still appears on output 1.
- m_ready_i[0]=0 during a packet to output 0 → s_ready_o=0 after the first beat. Output 0 holds 0xA1 stable. Releasing m_ready_i[0] resumes flow with no beat lost or duplicated.
- Packet to id 0 (last) immediately followed by a packet to id 1 → accepted in consecutive cycles, and each output shows exactly its own beats.
- STREAM_COUNT=3, STREAM_DEMUX_DROP_EN defined, head id=3 with a 2-beat packet → both beats are accepted, no output becomes valid, and drop_cnt_o=1. Without the macro, the same packet appears on output 2.

Source files
------------

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream router with one registered stage per output.
// Define STREAM_DEMUX_DROP_EN to discard packets whose head ID is out of range.
module stream_demux #(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int T_QOS__WIDTH = 4,
  parameter  int STREAM_COUNT = 2,
  localparam int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o  [STREAM_COUNT],
  output logic [T_QOS__WIDTH-1:0] m_qos_o   [STREAM_COUNT],
  output logic [STREAM_COUNT-1:0] m_last_o,
  output logic [STREAM_COUNT-1:0] m_valid_o,
  input  logic [STREAM_COUNT-1:0] m_ready_i,
  output logic [15:0]             drop_cnt_o
);

`ifdef STREAM_DEMUX_DROP_EN
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PKT} state_t;
`endif

  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

  state_t                    state, state_next;
  logic [T_ID___WIDTH-1:0]   sel, sel_next;
  logic [T_ID___WIDTH-1:0]   route, head_dest;
  logic                      in_range, dest_free, routing, accept;
  logic [STREAM_COUNT-1:0]   load;

  always_comb begin
    in_range = 1'b0;
    for (int unsigned k = 0; k < STREAM_COUNT; k++)
      if (s_id_i == T_ID___WIDTH'(k)) in_range = 1'b1;
    head_dest = in_range ? s_id_i : LAST_ID;
    // A head beat is steered by the live ID; later beats by the latched sel.
    route = (state == IDLE) ? head_dest : sel;

    dest_free = 1'b0;
    for (int unsigned k = 0; k < STREAM_COUNT; k++)
      if (route == T_ID___WIDTH'(k)) dest_free = !m_valid_o[k] | m_ready_i[k];

    routing   = 1'b1;
    s_ready_o = dest_free;
`ifdef STREAM_DEMUX_DROP_EN
    if (state == DROP || (state == IDLE && !in_range)) begin
      routing   = 1'b0;
      s_ready_o = 1'b1;
    end
`endif
    accept = s_valid_i & s_ready_o;

    load = '0;
    for (int unsigned k = 0; k < STREAM_COUNT; k++)
      load[k] = accept & routing & (route == T_ID___WIDTH'(k));

    state_next = state;
    sel_next   = sel;
    if (accept) begin
      case (state)
        IDLE: begin
          sel_next = head_dest;
          if (!s_last_i) begin
`ifdef STREAM_DEMUX_DROP_EN
            state_next = routing ? PKT : DROP;
`else
            state_next = PKT;
`endif
          end
        end
        default: if (s_last_i) state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o <= '0;
      m_last_o  <= '0;
      for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
        m_data_o[k] <= '0;
        m_qos_o[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
        if (load[k]) begin
          m_data_o[k]  <= s_data_i;
          m_qos_o[k]   <= s_qos_i;
          m_last_o[k]  <= s_last_i;
          m_valid_o[k] <= 1'b1;
        end else if (m_ready_i[k]) begin
          m_valid_o[k] <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_o <= '0;
    else if (accept && state == IDLE && !in_range && drop_cnt_o != '1)
      drop_cnt_o <= drop_cnt_o + 16'd1;
  end
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized bench for stream_demux (STREAM_COUNT=3) against a per-output beat queue model.
// Honours STREAM_DEMUX_DROP_EN the same way the design does.
module tb_stream_demux;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int SC = 3;
  localparam int IW = $clog2(SC);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic [QW-1:0] s_qos;
  logic [IW-1:0] s_id;
  logic          s_last, s_valid, s_ready;
  logic [DW-1:0] m_data [SC];
  logic [QW-1:0] m_qos  [SC];
  logic [SC-1:0] m_last, m_valid, m_ready;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  stream_demux #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_qos_o(m_qos), .m_last_o(m_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .drop_cnt_o(drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [QW-1:0] q;
    logic          l;
  } beat_t;

  // Beats accepted for output k but not yet taken by its consumer.
  beat_t exp_q [SC][$];
  bit    in_pkt, pkt_drop;
  int    pkt_dest;
  int    exp_drops;
  int    vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < SC; k++) exp_q[k].delete();
    in_pkt = 0; pkt_drop = 0; pkt_dest = 0; exp_drops = 0;
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < SC; k++) begin
      chk($sformatf("m_valid[%0d]", k), 32'(m_valid[k]), 32'(exp_q[k].size() != 0));
      if (exp_q[k].size() != 0) begin
        chk($sformatf("m_data[%0d]", k), 32'(m_data[k]), 32'(exp_q[k][0].d));
        chk($sformatf("m_qos[%0d]", k),  32'(m_qos[k]),  32'(exp_q[k][0].q));
        chk($sformatf("m_last[%0d]", k), 32'(m_last[k]), 32'(exp_q[k][0].l));
      end
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
  endtask

  task automatic step(input bit v, input int id, input logic [DW-1:0] d,
                      input logic [QW-1:0] q, input bit l, input logic [SC-1:0] rdy);
    int dest;
    bit drop, exp_rdy;
    @(negedge clk);
    compare_outputs();
    s_valid = v; s_id = IW'(id); s_data = d; s_qos = q; s_last = l; m_ready = rdy;
    #1;
    if (in_pkt) begin
      dest = pkt_dest; drop = pkt_drop;
    end else begin
      dest = id; drop = 0;
      if (id >= SC) begin
`ifdef STREAM_DEMUX_DROP_EN
        drop = 1;
`else
        dest = SC - 1;
`endif
      end
    end
    exp_rdy = drop ? 1'b1 : (exp_q[dest].size() == 0 || rdy[dest]);
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    for (int k = 0; k < SC; k++)
      if (exp_q[k].size() != 0 && rdy[k]) void'(exp_q[k].pop_front());
    if (v && exp_rdy) begin
      if (drop) begin
        if (!in_pkt && exp_drops < 65535) exp_drops++;
      end else begin
        exp_q[dest].push_back('{d: d, q: q, l: l});
      end
      in_pkt = !l; pkt_dest = dest; pkt_drop = drop;
    end
    vectors++;
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b1; s_id = 1; s_data = 8'h55; s_qos = 4'h3; s_last = 1'b0; m_ready = '1;
    #1;
    model_clear();
    chk("rst m_valid", 32'(m_valid), 32'h0);
    chk("rst m_last", 32'(m_last), 32'h0);
    for (int k = 0; k < SC; k++) begin
      chk($sformatf("rst m_data[%0d]", k), 32'(m_data[k]), 32'h0);
      chk($sformatf("rst m_qos[%0d]", k), 32'(m_qos[k]), 32'h0);
    end
    chk("rst drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst s_ready", 32'(s_ready), 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    s_valid = 0; s_id = 0; s_data = 0; s_qos = 0; s_last = 0; m_ready = '1;
    do_reset();

    // 3-beat packet to output 1, ID wanders mid-packet
    step(1, 1, 8'hA1, 4'h5, 0, 3'b111); peek();
    chk("pkt1 b1 valid", 32'(m_valid), 32'b010);
    chk("pkt1 b1 data", 32'(m_data[1]), 32'hA1);
    step(1, 0, 8'hA2, 4'h5, 0, 3'b111); peek();
    chk("pkt1 b2 valid", 32'(m_valid), 32'b010);
    chk("pkt1 b2 data", 32'(m_data[1]), 32'hA2);
    step(1, 0, 8'hA3, 4'h5, 1, 3'b111); peek();
    chk("pkt1 b3 data", 32'(m_data[1]), 32'hA3);
    chk("pkt1 b3 last", 32'(m_last[1]), 32'h1);
    step(0, 0, 8'h00, 4'h0, 0, 3'b111); peek();
    chk("pkt1 drained", 32'(m_valid), 32'h0);

    // Back-pressure on output 0
    step(1, 0, 8'hA1, 4'h2, 0, 3'b110); peek();
    chk("bp head data", 32'(m_data[0]), 32'hA1);
    step(1, 0, 8'hA2, 4'h2, 1, 3'b110);
    chk("bp s_ready low", 32'(s_ready), 32'h0);
    peek();
    chk("bp hold data", 32'(m_data[0]), 32'hA1);
    step(1, 0, 8'hA2, 4'h2, 1, 3'b110); peek();
    chk("bp still held", 32'(m_data[0]), 32'hA1);
    step(1, 0, 8'hA2, 4'h2, 1, 3'b111);
    chk("bp release ready", 32'(s_ready), 32'h1);
    peek();
    chk("bp second beat", 32'(m_data[0]), 32'hA2);
    step(0, 0, 8'h00, 4'h0, 0, 3'b111);

    // Back-to-back single-beat packets to different outputs
    step(1, 0, 8'hC1, 4'h1, 1, 3'b111);
    chk("b2b A ready", 32'(s_ready), 32'h1);
    peek();
    chk("b2b A on out0", 32'(m_valid), 32'b001);
    step(1, 1, 8'hD1, 4'h7, 1, 3'b111);
    chk("b2b B ready", 32'(s_ready), 32'h1);
    peek();
    chk("b2b B on out1", 32'(m_valid), 32'b010);
    chk("b2b B data", 32'(m_data[1]), 32'hD1);
    step(0, 0, 8'h00, 4'h0, 0, 3'b111);

    // Out-of-range head ID, 2-beat packet
    step(1, 3, 8'hE1, 4'h9, 0, 3'b111);
    chk("oor head ready", 32'(s_ready), 32'h1);
    step(1, 1, 8'hE2, 4'h9, 1, 3'b111);
    chk("oor tail ready", 32'(s_ready), 32'h1);
    peek();
`ifdef STREAM_DEMUX_DROP_EN
    chk("oor dropped valid", 32'(m_valid), 32'h0);
    chk("oor drop_cnt", 32'(drop_cnt), 32'h1);
`else
    chk("oor routed valid", 32'(m_valid), 32'b100);
    chk("oor routed data", 32'(m_data[2]), 32'hE2);
    chk("oor drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    step(0, 0, 8'h00, 4'h0, 0, 3'b111);

    // Randomized traffic, with a reset landing mid-stream
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
           4'($urandom), $urandom_range(0, 2) == 0, 3'($urandom));
    end
    step(0, 0, 8'h00, 4'h0, 0, 3'b111);
    step(0, 0, 8'h00, 4'h0, 0, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
